// File: rtl/jtag_seq_pkg.sv
// -----------------------------------------------------------------------------
// jtag_seq_pkg
//   Shared definitions for the JTAG scan sequencer: host op encodings, the
//   sequencer FSM state enum, and the fixed TMS patterns used to walk the TAP
//   between Run-Test/Idle and the shift states. Patterns are stored LSB-first:
//   bit 0 is the TMS value of the first tick of that phase.
// -----------------------------------------------------------------------------
package jtag_seq_pkg;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_IR_SCAN = 2'd1,
    OP_DR_SCAN = 2'd2,
    OP_IDLE    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AUTORST,
    S_PRE,
    S_SHIFT,
    S_POST,
    S_RESP
  } state_e;

  // Five ones reach Test-Logic-Reset from any state, the final zero parks in Run-Test/Idle.
  localparam logic [5:0] RST_TMS    = 6'b011111;
  localparam int         RST_LEN    = 6;
  // RTI -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
  localparam logic [3:0] IR_PRE_TMS = 4'b0011;
  localparam int         IR_PRE_LEN = 4;
  // RTI -> Select-DR -> Capture-DR -> Shift-DR
  localparam logic [2:0] DR_PRE_TMS = 3'b001;
  localparam int         DR_PRE_LEN = 3;
  // Exit1 -> Update -> RTI (Exit1 is entered by the TMS=1 on the last shift tick)
  localparam logic [1:0] POST_TMS   = 2'b01;
  localparam int         POST_LEN   = 2;

endpackage

// File: rtl/jtag_scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// jtag_scan_sequencer_if
//   Host command / response channel of the JTAG scan sequencer.
//   cmd_*  : valid/ready command (op, len, TDI data, bit 0 shifted first)
//   rsp_*  : valid/ready response (captured TDO bits, reject flag)
//   master : host side, slave : sequencer side.
// -----------------------------------------------------------------------------
interface jtag_scan_sequencer_if #(
  parameter int MAX_LEN = 80,
  parameter int LEN_W   = 7
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_tck_gen.sv
// -----------------------------------------------------------------------------
// jtag_tck_gen
//   TCK divider. While en is high, produces TCK_DIV CK cycles low followed by
//   TCK_DIV CK cycles high; forced low and phase-reset while en is low.
//   Ports: CK, TRST (async active-low), en,
//          tck_o    - generated TCK
//          rise_stb - last CK cycle of the low phase (next edge raises TCK)
//          fall_stb - last CK cycle of the high phase (next edge lowers TCK)
// -----------------------------------------------------------------------------
module jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic CK,
  input  logic TRST,
  input  logic en,
  output logic tck_o,
  output logic fall_stb,
  output logic rise_stb
);
  localparam int              PH_W    = $clog2(TCK_DIV) + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(TCK_DIV - 1);

  logic [PH_W-1:0] ph_q, ph_d;
  logic            tck_q, tck_d;
  logic            half_end;

  assign half_end = en && (ph_q == PH_LAST);

  always_comb begin
    ph_d  = '0;
    tck_d = 1'b0;
    if (en) begin
      if (half_end) begin
        tck_d = ~tck_q;
      end else begin
        ph_d  = ph_q + PH_W'(1);
        tck_d = tck_q;
      end
    end
  end

  always_ff @(posedge CK or negedge TRST) begin
    if (!TRST) begin
      ph_q  <= '0;
      tck_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o    = tck_q;
  assign rise_stb = half_end & ~tck_q;
  assign fall_stb = half_end &  tck_q;
endmodule

// File: rtl/jtag_scan_sequencer.sv
// -----------------------------------------------------------------------------
// jtag_scan_sequencer
//   On-chip JTAG master. Turns host commands (TAP reset, IR scan, DR scan,
//   idle ticks) into TCK/TMS/TDI waveforms and returns captured TDO bits.
//   Ports: CK, TRST (async active-low), bus (command/response, slave side),
//          busy (TCK sequence running), tck_o/tms_o/tdi_o to the TAP, tdo_i.
//   Every tick boundary (fall of TCK) advances the FSM, so TMS/TDI change
//   together with the falling TCK and TDO is sampled at the end of the high
//   phase, just before the TAP drives its next bit.
// -----------------------------------------------------------------------------
module jtag_scan_sequencer
  import jtag_seq_pkg::*;
#(
  parameter int MAX_LEN = 80,
  parameter int LEN_W   = 7,
  parameter int TCK_DIV = 2
) (
  input  logic                   CK,
  input  logic                   TRST,
  jtag_scan_sequencer_if.slave   bus,
  output logic                   busy,
  output logic                   tck_o,
  output logic                   tms_o,
  output logic                   tdi_o,
  input  logic                   tdo_i
);
  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d, plen;
  logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d, shift_sel, data_sh;
  logic               err_q, err_d, known_q, known_d, tms_q, tms_d, tdi_q, tdi_d;
  logic               fall_stb, rise_stb, last_tick;
  logic               unused_rise;

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .CK       (CK),
    .TRST     (TRST),
    .en       (busy),
    .tck_o    (tck_o),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );
  // TMS/TDI are launched at the fall, so the rising strobe has no consumer here.
  assign unused_rise = rise_stb;

  // One-hot capture slot for the current shift index.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_sel
    assign shift_sel[gi] = (cnt_q == LEN_W'(gi));
  end

  // TMS value for tick idx of phase st.
  function automatic logic tms_bit(state_e st, op_e op, logic [LEN_W-1:0] idx,
                                   logic [LEN_W-1:0] len);
    logic [7:0] pat;
    pat = '0;
    case (st)
      S_AUTORST: pat = 8'(RST_TMS);
      S_PRE: begin
        if (op == OP_IR_SCAN)      pat = 8'(IR_PRE_TMS);
        else if (op == OP_DR_SCAN) pat = 8'(DR_PRE_TMS);
      end
      S_POST:    pat = 8'(POST_TMS);
      default:   pat = '0;
    endcase
    pat = pat >> idx;
    if (st == S_SHIFT) return idx == (len - LEN_W'(1));
    return pat[0];
  endfunction

  always_comb begin
    plen = LEN_W'(POST_LEN);
    case (state_q)
      S_AUTORST: plen = LEN_W'(RST_LEN);
      S_PRE: begin
        if (op_q == OP_IR_SCAN)      plen = LEN_W'(IR_PRE_LEN);
        else if (op_q == OP_DR_SCAN) plen = LEN_W'(DR_PRE_LEN);
        else                         plen = len_q;  // IDLE op: len ticks of TMS=0
      end
      S_SHIFT:   plen = len_q;
      default:   plen = LEN_W'(POST_LEN);
    endcase
  end

  assign last_tick = (cnt_q == plen - LEN_W'(1));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    cap_d   = cap_q;
    err_d   = err_q;
    known_d = known_q;
    tms_d   = tms_q;
    tdi_d   = 1'b0;
    data_sh = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = op_e'(bus.cmd_op);
          len_d  = bus.cmd_len;
          data_d = bus.cmd_data;
          cnt_d  = '0;
          cap_d  = '0;
          err_d  = 1'b0;
          case (op_e'(bus.cmd_op))
            OP_RESET: state_d = S_AUTORST;
            OP_IDLE:  state_d = (bus.cmd_len == '0) ? S_IDLE : S_PRE;
            default: begin
              if (bus.cmd_len == '0 || bus.cmd_len > LEN_W'(MAX_LEN)) begin
                state_d = S_RESP;
                err_d   = 1'b1;
              end else begin
                state_d = known_q ? S_PRE : S_AUTORST;
              end
            end
          endcase
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
          cap_d   = '0;
        end
      end
      default: begin
        if (fall_stb) begin
          if (state_q == S_SHIFT) cap_d = cap_q | (shift_sel & {MAX_LEN{tdo_i}});
          if (last_tick) begin
            cnt_d = '0;
            case (state_q)
              S_AUTORST: begin
                known_d = 1'b1;
                state_d = (op_q == OP_RESET) ? S_IDLE : S_PRE;
              end
              S_PRE:   state_d = (op_q == OP_IDLE) ? S_IDLE : S_SHIFT;
              S_SHIFT: state_d = S_POST;
              default: state_d = S_RESP;
            endcase
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
    endcase
    // Pins follow the tick about to start; outside sequences TMS holds its last value.
    if (state_d inside {S_AUTORST, S_PRE, S_SHIFT, S_POST})
      tms_d = tms_bit(state_d, op_d, cnt_d, len_d);
    if (state_d == S_SHIFT) begin
      data_sh = data_d >> cnt_d;
      tdi_d   = data_sh[0];
    end
  end

  always_ff @(posedge CK or negedge TRST) begin
    if (!TRST) begin
      state_q <= S_IDLE;
      op_q    <= OP_RESET;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      err_q   <= 1'b0;
      known_q <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
      known_q <= known_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  assign busy          = state_q inside {S_AUTORST, S_PRE, S_SHIFT, S_POST};
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = cap_q;
  assign bus.rsp_err   = err_q;
  assign tms_o         = tms_q;
  assign tdi_o         = tdi_q;
endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jtag_scan_sequencer
//   Two sequencers (TCK_DIV=1 and TCK_DIV=3) share clock, reset and command
//   inputs; sel routes the handshake to one of them. Each drives its own
//   behavioural TAP (2-bit IR capturing 2'b01, 1-bit bypass register).
// -----------------------------------------------------------------------------
module tb_jtag_scan_sequencer;
  logic        CK = 1'b0;
  logic        TRST = 1'b0;
  logic        sel = 1'b0;
  logic        v = 1'b0, rr = 1'b0;
  logic [1:0]  op = '0;
  logic [6:0]  len = '0;
  logic [79:0] data = '0;

  logic [1:0]  tck_w, tms_w, tdi_w, tdo_w, busy_w;
  int          checks = 0, failures = 0;
  int          tck_edges = 0, hi_cyc = 0;
  logic [31:0] tms_hist = '0, tdi_hist = '0;

  always #5 CK = ~CK;

  jtag_scan_sequencer_if #(.MAX_LEN(80), .LEN_W(7)) if0 ();
  jtag_scan_sequencer_if #(.MAX_LEN(80), .LEN_W(7)) if1 ();

  assign if0.cmd_valid = v & ~sel;
  assign if1.cmd_valid = v & sel;
  assign if0.rsp_ready = rr & ~sel;
  assign if1.rsp_ready = rr & sel;
  assign if0.cmd_op = op;   assign if1.cmd_op = op;
  assign if0.cmd_len = len; assign if1.cmd_len = len;
  assign if0.cmd_data = data; assign if1.cmd_data = data;

  jtag_scan_sequencer #(.MAX_LEN(80), .LEN_W(7), .TCK_DIV(1)) dut0 (
    .CK(CK), .TRST(TRST), .bus(if0), .busy(busy_w[0]),
    .tck_o(tck_w[0]), .tms_o(tms_w[0]), .tdi_o(tdi_w[0]), .tdo_i(tdo_w[0]));
  jtag_scan_sequencer #(.MAX_LEN(80), .LEN_W(7), .TCK_DIV(3)) dut1 (
    .CK(CK), .TRST(TRST), .bus(if1), .busy(busy_w[1]),
    .tck_o(tck_w[1]), .tms_o(tms_w[1]), .tdi_o(tdi_w[1]), .tdo_i(tdo_w[1]));

  logic        m_tck, m_tms, m_tdi, m_busy, m_ready, m_rvalid, m_rerr;
  logic [79:0] m_rdata;
  assign m_tck    = tck_w[sel];
  assign m_tms    = tms_w[sel];
  assign m_tdi    = tdi_w[sel];
  assign m_busy   = busy_w[sel];
  assign m_ready  = sel ? if1.cmd_ready : if0.cmd_ready;
  assign m_rvalid = sel ? if1.rsp_valid : if0.rsp_valid;
  assign m_rerr   = sel ? if1.rsp_err   : if0.rsp_err;
  assign m_rdata  = sel ? if1.rsp_data  : if0.rsp_data;

  always @(posedge m_tck) begin
    tck_edges <= tck_edges + 1;
    tms_hist  <= {tms_hist[30:0], m_tms};
    tdi_hist  <= {tdi_hist[30:0], m_tdi};
  end
  always @(posedge CK) if (m_tck) hi_cyc <= hi_cyc + 1;

  // TAP states: 0 TLR,1 RTI,2 SelDR,3 CapDR,4 ShDR,5 Ex1DR,6 PauDR,7 Ex2DR,8 UpdDR,
  //             9 SelIR,10 CapIR,11 ShIR,12 Ex1IR,13 PauIR,14 Ex2IR,15 UpdIR
  function automatic int tap_next(int s, logic t);
    case (s)
      0: return t ? 0 : 1;   1: return t ? 2 : 1;   2: return t ? 9 : 3;
      3: return t ? 5 : 4;   4: return t ? 5 : 4;   5: return t ? 8 : 6;
      6: return t ? 7 : 6;   7: return t ? 8 : 4;   8: return t ? 2 : 1;
      9: return t ? 0 : 10;  10: return t ? 12 : 11; 11: return t ? 12 : 11;
      12: return t ? 15 : 13; 13: return t ? 14 : 13; 14: return t ? 15 : 11;
      15: return t ? 2 : 1;
      default: return 0;
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_tap
    int         st = 4;      // starts in Shift-DR: the bench must reset it
    logic [1:0] ir_sh = 2'b00;
    logic       byp = 1'b0;
    logic       tdo_r = 1'b0;
    always @(posedge tck_w[gi]) begin
      case (st)
        10: ir_sh <= 2'b01;
        11: ir_sh <= {tdi_w[gi], ir_sh[1]};
        3:  byp   <= 1'b0;
        4:  byp   <= tdi_w[gi];
        default: ;
      endcase
      st <= tap_next(st, tms_w[gi]);
    end
    always @(negedge tck_w[gi]) begin
      if (st == 11)     tdo_r <= ir_sh[0];
      else if (st == 4) tdo_r <= byp;
    end
    assign tdo_w[gi] = tdo_r;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a command and return just after the posedge that accepts it.
  task automatic issue(input logic [1:0] o, input logic [6:0] l, input logic [79:0] d);
    int n;
    @(negedge CK);
    op = o; len = l; data = d; v = 1'b1;
    n = 0;
    while (!m_ready && n < 200) begin @(negedge CK); n++; end
    chk("cmd_ready_wait", m_ready, 1'b1);
    @(posedge CK);
  endtask

  // Issue, then count CK cycles with busy high; ends on the first negedge with busy low.
  task automatic run(input logic [1:0] o, input logic [6:0] l, input logic [79:0] d,
                     output int busy_cyc, output int edges);
    int n, e0;
    e0 = tck_edges;
    issue(o, l, d);
    busy_cyc = 0; n = 0;
    @(negedge CK); v = 1'b0;
    while (m_busy && n < 3000) begin busy_cyc++; @(negedge CK); n++; end
    chk("busy_bounded", m_busy, 1'b0);
    edges = tck_edges - e0;
  endtask

  task automatic take_rsp(input string tag, input logic [79:0] exp_d, input logic exp_e);
    chk({tag, "_rvalid"}, m_rvalid, 1'b1);
    chk({tag, "_rdata"}, m_rdata, exp_d);
    chk({tag, "_rerr"}, m_rerr, exp_e);
    rr = 1'b1;
    @(negedge CK);
    rr = 1'b0;
    chk({tag, "_rvalid_clr"}, m_rvalid, 1'b0);
    chk({tag, "_ready_back"}, m_ready, 1'b1);
  endtask

  initial begin
    int bc, ed, h0, n, e0;
    // 1: reset values and a quiet TCK
    repeat (3) @(negedge CK);
    TRST = 1'b1;
    @(negedge CK);
    chk("rst_tck", m_tck, 1'b0);
    chk("rst_tms", m_tms, 1'b1);
    chk("rst_tdi", m_tdi, 1'b0);
    chk("rst_ready", m_ready, 1'b1);
    chk("rst_rvalid", m_rvalid, 1'b0);
    chk("rst_rerr", m_rerr, 1'b0);
    chk("rst_rdata", m_rdata, 80'h0);
    chk("rst_busy", m_busy, 1'b0);
    repeat (20) @(negedge CK);
    chk("rst_no_tck", tck_edges, 0);

    // 2: TAP reset
    run(2'd0, 7'd0, 80'h0, bc, ed);
    chk("reset_busy_cyc", bc, 12);
    chk("reset_ticks", ed, 6);
    chk("reset_tms", tms_hist[5:0], 6'b111110);
    chk("reset_tap_rti", g_tap[0].st, 1);
    chk("reset_no_rsp", m_rvalid, 1'b0);
    chk("reset_ready", m_ready, 1'b1);

    // IDLE ticks, then IDLE len=0 (no tick at all)
    run(2'd3, 7'd3, 80'h0, bc, ed);
    chk("idle3_busy_cyc", bc, 6);
    chk("idle3_ticks", ed, 3);
    chk("idle3_tms", tms_hist[2:0], 3'b000);
    run(2'd3, 7'd0, 80'h0, bc, ed);
    chk("idle0_busy_cyc", bc, 0);
    chk("idle0_ticks", ed, 0);
    chk("idle0_ready", m_ready, 1'b1);

    // 3: IR scan, 2 bits
    run(2'd1, 7'd2, 80'h2, bc, ed);
    chk("ir_ticks", ed, 8);
    chk("ir_busy_cyc", bc, 16);
    chk("ir_tdi", tdi_hist[7:0], 8'b00000100);
    chk("ir_tms", tms_hist[7:0], 8'b11000110);
    chk("ir_tap_rti", g_tap[0].st, 1);
    take_rsp("ir", 80'h1, 1'b0);

    // 4: DR bypass, 8 bits, then again with a slow response consumer
    run(2'd2, 7'd8, 80'hA5, bc, ed);
    chk("dr_ticks", ed, 13);
    chk("dr_tdi", tdi_hist[12:0], 13'b0001010010100);
    chk("dr_tms", tms_hist[12:0], 13'b1000000000110);
    take_rsp("dr", 80'h4A, 1'b0);
    run(2'd2, 7'd8, 80'hA5, bc, ed);
    for (int i = 0; i < 5; i++) begin
      chk("dr_hold_rdata", m_rdata, 80'h4A);
      chk("dr_hold_ready", m_ready, 1'b0);
      chk("dr_hold_rvalid", m_rvalid, 1'b1);
      @(negedge CK);
    end
    take_rsp("dr_hold", 80'h4A, 1'b0);

    // 5: rejected lengths
    run(2'd2, 7'd0, 80'hFF, bc, ed);
    chk("len0_busy_cyc", bc, 0);
    chk("len0_ticks", ed, 0);
    take_rsp("len0", 80'h0, 1'b1);
    run(2'd2, 7'd81, {80{1'b1}}, bc, ed);
    chk("len81_busy_cyc", bc, 0);
    chk("len81_ticks", ed, 0);
    take_rsp("len81", 80'h0, 1'b1);

    // 6: TRST during the 3rd shift tick of a DR scan
    e0 = tck_edges;
    issue(2'd2, 7'd8, 80'hFF);
    @(negedge CK); v = 1'b0;
    n = 0;
    while (tck_edges - e0 < 6 && n < 500) begin @(negedge CK); n++; end
    chk("trst_tick_reached", tck_edges - e0, 6);
    TRST = 1'b0;
    #1;
    chk("trst_tck", m_tck, 1'b0);
    chk("trst_tms", m_tms, 1'b1);
    chk("trst_tdi", m_tdi, 1'b0);
    chk("trst_ready", m_ready, 1'b1);
    chk("trst_rvalid", m_rvalid, 1'b0);
    chk("trst_busy", m_busy, 1'b0);
    chk("trst_rdata", m_rdata, 80'h0);
    @(negedge CK);
    TRST = 1'b1;
    run(2'd2, 7'd1, 80'h1, bc, ed);
    chk("autorst_ticks", ed, 12);
    chk("autorst_busy_cyc", bc, 24);
    chk("autorst_tms", tms_hist[11:0], 12'b111110100110);
    chk("autorst_tap_rti", g_tap[0].st, 1);
    take_rsp("autorst", 80'h0, 1'b0);

    // TCK_DIV=3 instance: unknown TAP, so AUTORST precedes the bypass scan
    @(negedge CK);
    sel = 1'b1;
    h0 = hi_cyc;
    run(2'd2, 7'd8, 80'hA5, bc, ed);
    chk("div3_ticks", ed, 19);
    chk("div3_busy_cyc", bc, 114);
    chk("div3_high_cyc", hi_cyc - h0, 57);
    chk("div3_tap_rti", g_tap[1].st, 1);
    take_rsp("div3", 80'h4A, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
